// File: rtl/alu_i8_pkg.sv
// Shared opcodes, widths and the combinational i8 ALU function used by the pipelined unit.
package alu_i8_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;

    localparam logic [OP_W-1:0] OP_NOT = 3'd0;
    localparam logic [OP_W-1:0] OP_AND = 3'd1;
    localparam logic [OP_W-1:0] OP_OR  = 3'd2;
    localparam logic [OP_W-1:0] OP_XOR = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB = 3'd5;

    // Results wrap modulo 256; reserved opcodes yield zero.
    function automatic logic [DATA_W-1:0] alu_i8_f(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_i8_stage.sv
// One pipeline register: valid bit plus result data, advancing only when enabled.
module alu_i8_stage
    import alu_i8_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/alu_i8_pipe.sv
// Flow-controlled i8 ALU: LATENCY register stages, whole pipe freezes while the output is stalled.
module alu_i8_pipe
    import alu_i8_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    logic              w_stall;
    logic              w_accept;
    logic              w_vld [0:LATENCY];
    logic [DATA_W-1:0] w_dat [0:LATENCY];
    logic [CNT_W-1:0]  r_count;

    // Bubbles are not collapsed, so a held output freezes every stage behind it.
    assign w_stall  = w_vld[LATENCY] && !out_ready;
    assign in_ready = !w_stall && !reset;
    assign w_accept = in_valid && in_ready;

    assign w_vld[0] = w_accept;
    assign w_dat[0] = alu_i8_f(op, a, b);

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        alu_i8_stage u_stage (
            .clock   (clock),
            .reset   (reset),
            .i_en    (!w_stall),
            .i_valid (w_vld[i]),
            .i_data  (w_dat[i]),
            .o_valid (w_vld[i+1]),
            .o_data  (w_dat[i+1])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign y         = w_dat[LATENCY];
    assign out_valid = w_vld[LATENCY];
    assign count     = r_count;

endmodule

// File: tb/tb_alu_i8_pipe.sv
// Scoreboard bench: the driver queues hand-computed results on accept, the monitor checks deliveries.
module tb_alu_i8_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  op = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] count;

    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    int          exp_count = 0;

    alu_i8_pipe #(.LATENCY(2), .CNT_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #500 clock = ~clock;

    initial begin
        #(60000 * 1000);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Deliveries are judged just before the edge that completes them.
    initial begin
        forever begin
            @(negedge clock);
            #100;
            if (!reset && out_valid && out_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {24'd0, y}, 32'hDEAD);
                end else begin
                    check("result", {24'd0, y}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] expv);
        bit done = 0;
        op = o; a = va; b = vb; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #100;
            if (in_ready) begin
                exp_q.push_back(expv);
                exp_count++;
                done = 1;
            end
            @(negedge clock);
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clock);
        check("drain_empty", exp_q.size(), 32'd0);
        #150;
        check("count", count, exp_count);
        @(negedge clock);
    endtask

    initial begin
        int d0;
        repeat (16) @(negedge clock);
        #100;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_count", count, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // NOT with latency probe: accepted at edge N, visible after N+1.
        send(3'd0, 8'd3, 8'd0, 8'hFC);
        idle();
        #100;
        check("lat_early", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        #100;
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_y", {24'd0, y}, 32'hFC);
        @(negedge clock);
        drain();
        check("count_not", count, 32'd1);

        send(3'd4, 8'd200, 8'd100, 8'd44);
        send(3'd5, 8'd3, 8'd5, 8'hFE);
        send(3'd1, 8'hF0, 8'h3C, 8'h30);
        send(3'd2, 8'hF0, 8'h0F, 8'hFF);
        send(3'd3, 8'hAA, 8'hFF, 8'h55);
        idle();
        drain();

        // Back-to-back stream at full rate.
        d0 = n_deliv;
        for (int i = 0; i < 8; i++) send(3'd4, 8'(i), 8'd1, 8'(i + 1));
        idle();
        for (int t = 0; t < 2; t++) @(negedge clock);
        check("stream_deliv", n_deliv - d0, 32'd8);
        drain();

        // Back-pressure: consumer stalls 5 cycles while 4 ops are offered.
        out_ready = 1'b0;
        d0 = n_deliv;
        fork
            begin
                send(3'd4, 8'd10, 8'd20, 8'd30);
                send(3'd5, 8'd0, 8'd1, 8'hFF);
                send(3'd1, 8'hFF, 8'h81, 8'h81);
                send(3'd2, 8'h40, 8'h02, 8'h42);
                idle();
            end
            begin
                for (int t = 0; t < 5; t++) begin
                    @(negedge clock);
                    #150;
                    if (out_valid) begin
                        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                        check("bp_y_hold", {24'd0, y}, 32'd30);
                    end
                end
                check("bp_stalled_valid", {31'd0, out_valid}, 32'd1);
                check("bp_no_deliv", n_deliv - d0, 32'd0);
                @(negedge clock);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_deliv", n_deliv - d0, 32'd4);

        // Reserved opcodes still handshake and count.
        d0 = n_deliv;
        send(3'd7, 8'h55, 8'h00, 8'h00);
        idle();
        for (int t = 0; t < 4; t++) @(negedge clock);
        check("rsv_pulse", n_deliv - d0, 32'd1);
        drain();
        send(3'd6, 8'hAA, 8'h11, 8'h00);
        idle();
        drain();

        // Reset with two results in flight.
        send(3'd4, 8'd1, 8'd1, 8'd2);
        send(3'd4, 8'd2, 8'd2, 8'd4);
        idle();
        reset = 1'b1;
        exp_q.delete();
        exp_count = 0;
        d0 = n_deliv;
        @(negedge clock);
        #100;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_y", {24'd0, y}, 32'd0);
        check("mid_rst_count", count, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int t = 0; t < 8; t++) @(negedge clock);
        check("post_rst_no_stale", n_deliv - d0, 32'd0);
        send(3'd3, 8'h0F, 8'hF0, 8'hFF);
        idle();
        drain();
        check("post_rst_count", count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
